// File: rtl/weight_update_unit.sv
// Weight store with per-weight gradient accumulators. Accepts gradient rows in IDLE and
// accumulates them. On batch_end it sweeps every row once to apply w -= acc >>> LR_SHIFT.
module weight_update_unit #(
  parameter int DATA_SIZE      = 8,
  parameter int FRAC_BITS      = 4,
  parameter int SIZE           = 3,
  parameter int MAX_LAYER_SIZE = 4,
  parameter int LR_SHIFT       = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              grad_valid,
  output logic                              grad_ready,
  input  logic [$clog2(MAX_LAYER_SIZE)-1:0] grad_layer,
  input  logic [$clog2(SIZE)-1:0]           grad_row,
  input  logic [DATA_SIZE*SIZE-1:0]         grad_stream,
  input  logic                              batch_end,
  input  logic                              wr_en,
  input  logic [$clog2(MAX_LAYER_SIZE)-1:0] wr_layer,
  input  logic [$clog2(SIZE)-1:0]           wr_row,
  input  logic [DATA_SIZE*SIZE-1:0]         wr_data,
  input  logic [$clog2(MAX_LAYER_SIZE)-1:0] rd_layer,
  input  logic [$clog2(SIZE)-1:0]           rd_row,
  output logic [DATA_SIZE*SIZE-1:0]         rd_data,
  output logic                              busy,
  output logic                              done,
  output logic                              sat_seen
);

  localparam int LW = $clog2(MAX_LAYER_SIZE);
  localparam int RW = $clog2(SIZE);
  localparam logic [LW-1:0] LAST_LAYER = LW'(MAX_LAYER_SIZE - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(SIZE - 1);

  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_SIZE) begin : g_bad_frac_bits
    $error("FRAC_BITS must lie in [0, DATA_SIZE)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef logic signed [DATA_SIZE-1:0] elem_t;
  typedef logic signed [DATA_SIZE:0]   wide_t;

  state_t        r_state;
  state_t        w_state_next;
  elem_t         r_w   [MAX_LAYER_SIZE][SIZE][SIZE];
  elem_t         r_acc [MAX_LAYER_SIZE][SIZE][SIZE];
  logic [LW-1:0] r_sw_layer;
  logic [RW-1:0] r_sw_row;
  logic          r_sat_seen;

  logic          w_grad_ok;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [LW-1:0] w_gl;
  logic [RW-1:0] w_gr;
  logic [LW-1:0] w_wl;
  logic [RW-1:0] w_wr;
  logic [LW-1:0] w_rl;
  logic [RW-1:0] w_rr;
  logic          w_accept;
  logic          w_sweep_last;
  elem_t         w_grad     [SIZE];
  elem_t         w_wr_elem  [SIZE];
  wide_t         w_acc_wide [SIZE];
  elem_t         w_step     [SIZE];
  wide_t         w_upd_wide [SIZE];
  logic          w_acc_ovf;
  logic          w_upd_ovf;
  logic          w_sat_event;

  // A wide sum overflowed DATA_SIZE when its top two bits disagree.
  function automatic logic ovf(input wide_t s);
    return s[DATA_SIZE] ^ s[DATA_SIZE-1];
  endfunction

  function automatic elem_t sat_clip(input wide_t s);
    if (ovf(s)) begin
      return s[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
    return s[DATA_SIZE-1:0];
  endfunction

  function automatic logic in_range(input int layer, input int row);
    return (layer < MAX_LAYER_SIZE) && (row < SIZE);
  endfunction

  // Out-of-range addresses are flagged and steered to row 0 so array reads stay in bounds.
  always_comb begin
    w_grad_ok = in_range(int'(grad_layer), int'(grad_row));
    w_wr_ok   = in_range(int'(wr_layer), int'(wr_row));
    w_rd_ok   = in_range(int'(rd_layer), int'(rd_row));
    w_gl      = w_grad_ok ? grad_layer : '0;
    w_gr      = w_grad_ok ? grad_row   : '0;
    w_wl      = w_wr_ok   ? wr_layer   : '0;
    w_wr      = w_wr_ok   ? wr_row     : '0;
    w_rl      = w_rd_ok   ? rd_layer   : '0;
    w_rr      = w_rd_ok   ? rd_row     : '0;
  end

  always_comb begin
    w_accept     = grad_valid && (r_state == S_IDLE);
    w_sweep_last = (r_sw_layer == LAST_LAYER) && (r_sw_row == LAST_ROW);
    w_acc_ovf    = 1'b0;
    w_upd_ovf    = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      w_grad[i]     = elem_t'(grad_stream[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE]);
      w_wr_elem[i]  = elem_t'(wr_data[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE]);
      w_acc_wide[i] = wide_t'(r_acc[w_gl][w_gr][i]) + wide_t'(w_grad[i]);
      w_step[i]     = r_acc[r_sw_layer][r_sw_row][i] >>> LR_SHIFT;
      w_upd_wide[i] = wide_t'(r_w[r_sw_layer][r_sw_row][i]) - wide_t'(w_step[i]);
      w_acc_ovf     = w_acc_ovf | ovf(w_acc_wide[i]);
      w_upd_ovf     = w_upd_ovf | ovf(w_upd_wide[i]);
    end
    w_sat_event = (w_accept && w_grad_ok && w_acc_ovf) ||
                  ((r_state == S_APPLY) && w_upd_ovf);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would
  // make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (batch_end) w_state_next = S_APPLY;
      S_APPLY: if (w_sweep_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grad_ready = (r_state == S_IDLE);
    busy       = (r_state == S_APPLY) || (r_state == S_DONE);
    done       = (r_state == S_DONE);
    sat_seen   = r_sat_seen;
  end

  // NOTE: the stores are flop arrays, not RAM, because reset must zero every weight and
  // accumulator in one cycle; that forbids inferring a memory macro here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_layer <= '0;
      r_sw_row   <= '0;
      r_sat_seen <= 1'b0;
      for (int l = 0; l < MAX_LAYER_SIZE; l++) begin
        for (int r = 0; r < SIZE; r++) begin
          for (int i = 0; i < SIZE; i++) begin
            r_w[l][r][i]   <= '0;
            r_acc[l][r][i] <= '0;
          end
        end
      end
    end else begin
      if (w_sat_event) r_sat_seen <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (wr_en && w_wr_ok) begin
            for (int i = 0; i < SIZE; i++) r_w[w_wl][w_wr][i] <= w_wr_elem[i];
          end
          if (w_accept && w_grad_ok) begin
            for (int i = 0; i < SIZE; i++) r_acc[w_gl][w_gr][i] <= sat_clip(w_acc_wide[i]);
          end
          if (batch_end) begin
            r_sw_layer <= '0;
            r_sw_row   <= '0;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < SIZE; i++) begin
            r_w[r_sw_layer][r_sw_row][i]   <= sat_clip(w_upd_wide[i]);
            r_acc[r_sw_layer][r_sw_row][i] <= '0;
          end
          if (r_sw_row == LAST_ROW) begin
            r_sw_row   <= '0;
            r_sw_layer <= r_sw_layer + LW'(1);
          end else begin
            r_sw_row <= r_sw_row + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (w_rd_ok) begin
      for (int i = 0; i < SIZE; i++) begin
        rd_data[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE] = r_w[w_rl][w_rr][i];
      end
    end
  end

endmodule

// File: tb/tb_weight_update_unit.sv
// Bench for weight_update_unit: directed table, multi-cycle corner sequences, and a
// randomized run against an arithmetic reference model of the weight/accumulator store.
`timescale 1ns/1ps
module tb_weight_update_unit;

  localparam int DS    = 8;
  localparam int SZ    = 3;
  localparam int NL    = 4;
  localparam int LR    = 2;
  localparam int SWEEP = NL * SZ;

  logic        clk = 1'b0;
  logic        reset;
  logic        grad_valid;
  logic        grad_ready;
  logic [1:0]  grad_layer;
  logic [1:0]  grad_row;
  logic [23:0] grad_stream;
  logic        batch_end;
  logic        wr_en;
  logic [1:0]  wr_layer;
  logic [1:0]  wr_row;
  logic [23:0] wr_data;
  logic [1:0]  rd_layer;
  logic [1:0]  rd_row;
  logic [23:0] rd_data;
  logic        busy;
  logic        done;
  logic        sat_seen;

  weight_update_unit #(
    .DATA_SIZE(DS), .FRAC_BITS(4), .SIZE(SZ), .MAX_LAYER_SIZE(NL), .LR_SHIFT(LR)
  ) dut (
    .clk(clk), .reset(reset),
    .grad_valid(grad_valid), .grad_ready(grad_ready),
    .grad_layer(grad_layer), .grad_row(grad_row), .grad_stream(grad_stream),
    .batch_end(batch_end),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_row(wr_row), .wr_data(wr_data),
    .rd_layer(rd_layer), .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .sat_seen(sat_seen)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: weights/accumulators as plain integers, sweep as a linear index.
  int m_w   [NL][SZ][SZ];
  int m_acc [NL][SZ][SZ];
  int m_phase;  // 0 idle, 1 sweeping, 2 done cycle
  int m_k;
  bit m_sat;

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q = a / d;
    if ((a % d != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic int elem(input logic [23:0] d, input int i);
    byte b;
    b = d[(SZ-i)*DS-1 -: DS];
    return int'(b);
  endfunction

  function automatic bit addr_ok(input int l, input int r);
    return (l < NL) && (r < SZ);
  endfunction

  function automatic logic [23:0] m_row(input int l, input int r);
    logic [23:0] v = '0;
    if (!addr_ok(l, r)) return '0;
    for (int i = 0; i < SZ; i++) v = {v[15:0], 8'(m_w[l][r][i])};
    return v;
  endfunction

  task automatic model_edge();
    int s;
    if (reset) begin
      for (int l = 0; l < NL; l++)
        for (int r = 0; r < SZ; r++)
          for (int i = 0; i < SZ; i++) begin
            m_w[l][r][i] = 0;
            m_acc[l][r][i] = 0;
          end
      m_phase = 0;
      m_sat   = 0;
    end else if (m_phase == 0) begin
      if (wr_en && addr_ok(int'(wr_layer), int'(wr_row)))
        for (int i = 0; i < SZ; i++) m_w[wr_layer][wr_row][i] = elem(wr_data, i);
      if (grad_valid && addr_ok(int'(grad_layer), int'(grad_row)))
        for (int i = 0; i < SZ; i++) begin
          s = m_acc[grad_layer][grad_row][i] + elem(grad_stream, i);
          if (s != clamp8(s)) m_sat = 1;
          m_acc[grad_layer][grad_row][i] = clamp8(s);
        end
      if (batch_end) begin
        m_phase = 1;
        m_k     = 0;
      end
    end else if (m_phase == 1) begin
      for (int i = 0; i < SZ; i++) begin
        s = m_w[m_k / SZ][m_k % SZ][i] - floor_div(m_acc[m_k / SZ][m_k % SZ][i], 1 << LR);
        if (s != clamp8(s)) m_sat = 1;
        m_w[m_k / SZ][m_k % SZ][i]   = clamp8(s);
        m_acc[m_k / SZ][m_k % SZ][i] = 0;
      end
      m_k++;
      if (m_k == SWEEP) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    grad_valid = 0; grad_layer = 0; grad_row = 0; grad_stream = 0;
    batch_end = 0; wr_en = 0; wr_layer = 0; wr_row = 0; wr_data = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_ready"}, 64'(grad_ready), 64'(m_phase == 0));
    check({tag, "_busy"},  64'(busy),       64'(m_phase != 0));
    check({tag, "_done"},  64'(done),       64'(m_phase == 2));
    check({tag, "_sat"},   64'(sat_seen),   64'(m_sat));
    check({tag, "_rd"},    64'(rd_data),    64'(m_row(int'(rd_layer), int'(rd_row))));
  endtask

  task automatic check_rd(input int l, input int r, input logic [23:0] exp, input string name);
    rd_layer = 2'(l);
    rd_row   = 2'(r);
    #0.1;
    check(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic load(input int l, input int r, input logic [23:0] d);
    wr_en = 1; wr_layer = 2'(l); wr_row = 2'(r); wr_data = d;
    tick();
    idle_in();
  endtask

  task automatic grad(input int l, input int r, input logic [23:0] d);
    grad_valid = 1; grad_layer = 2'(l); grad_row = 2'(r); grad_stream = d;
    tick();
    idle_in();
  endtask

  // batch_end pulse, then wait (bounded) for done: it must appear SWEEP edges later.
  task automatic run_sweep(input string name);
    int n = 0;
    batch_end = 1;
    tick();
    batch_end = 0;
    while (n < 100 && done !== 1'b1) begin
      tick();
      n++;
    end
    check({name, "_done_lat"}, 64'(n), 64'(SWEEP));
    tick();
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          kind;  // 0 load, 1 gradient, 2 sweep
    int          layer;
    int          row;
    logic [23:0] data;
    logic [23:0] exp_rd;
    bit          exp_sat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 0, 0, 24'h201000, 24'h201000, 1'b0, "load_w00"};
    vecs[1]  = '{1, 0, 0, 24'h1000F0, 24'h201000, 1'b0, "grad_w00_a"};
    vecs[2]  = '{1, 0, 0, 24'h1000F0, 24'h201000, 1'b0, "grad_w00_b"};
    vecs[3]  = '{2, 0, 0, 24'h000000, 24'h181008, 1'b0, "sweep_w00"};
    vecs[4]  = '{2, 0, 0, 24'h000000, 24'h181008, 1'b0, "sweep_empty"};
    vecs[5]  = '{0, 1, 2, 24'h807F00, 24'h807F00, 1'b0, "load_w12"};
    vecs[6]  = '{1, 1, 2, 24'h7F8000, 24'h807F00, 1'b0, "grad_w12_a"};
    vecs[7]  = '{1, 1, 2, 24'h7F8000, 24'h807F00, 1'b1, "grad_w12_sat"};
    vecs[8]  = '{1, 1, 2, 24'h7F8000, 24'h807F00, 1'b1, "grad_w12_c"};
    vecs[9]  = '{2, 1, 2, 24'h000000, 24'h807F00, 1'b1, "sweep_w12_sat"};
    vecs[10] = '{0, 2, 3, 24'h112233, 24'h000000, 1'b1, "load_oor"};
    vecs[11] = '{1, 2, 3, 24'h7F7F7F, 24'h000000, 1'b1, "grad_oor"};

    idle_in();
    rd_layer = 0; rd_row = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;

    check("rst_ready", 64'(grad_ready), 64'd1);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_done",  64'(done),       64'd0);
    check("rst_sat",   64'(sat_seen),   64'd0);
    for (int l = 0; l < NL; l++)
      for (int r = 0; r <= SZ; r++) check_rd(l, r, 24'h0, "rst_rd");

    for (int n = 0; n < 12; n++) begin
      idle_in();
      case (vecs[n].kind)
        0: load(vecs[n].layer, vecs[n].row, vecs[n].data);
        1: grad(vecs[n].layer, vecs[n].row, vecs[n].data);
        default: run_sweep(vecs[n].name);
      endcase
      check_rd(vecs[n].layer, vecs[n].row, vecs[n].exp_rd, vecs[n].name);
      check({vecs[n].name, "_sat"}, 64'(sat_seen), 64'(vecs[n].exp_sat));
    end

    // Gradients offered throughout a sweep must be refused.
    load(0, 1, 24'h050607);
    batch_end = 1;
    tick();
    batch_end = 0;
    grad_valid = 1; grad_layer = 0; grad_row = 1; grad_stream = 24'h101010;
    for (int n = 1; n <= SWEEP; n++) begin
      tick();
      check("hold_ready", 64'(grad_ready), 64'd0);
      compare_model("hold");
    end
    check("hold_done", 64'(done), 64'd1);
    idle_in();
    tick();
    check("hold_back_idle", 64'(grad_ready), 64'd1);
    check_rd(0, 1, 24'h050607, "hold_w01");
    run_sweep("hold_resweep");
    check_rd(0, 1, 24'h050607, "hold_w01_again");

    // Reset in the middle of a sweep aborts it and zeroes everything.
    grad(0, 0, 24'h404040);
    load(2, 0, 24'h333333);
    batch_end = 1;
    tick();
    batch_end = 0;
    for (int n = 0; n < 5; n++) tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort_busy",  64'(busy),       64'd0);
    check("abort_ready", 64'(grad_ready), 64'd1);
    check("abort_sat",   64'(sat_seen),   64'd0);
    for (int n = 0; n < 20; n++) begin
      check("abort_no_done", 64'(done), 64'd0);
      tick();
    end
    for (int l = 0; l < NL; l++)
      for (int r = 0; r < SZ; r++) check_rd(l, r, 24'h0, "abort_rd");
    load(0, 0, 24'h101010);
    run_sweep("abort_acc_zero");
    check_rd(0, 0, 24'h101010, "abort_acc_w00");

    // Gradient accepted with batch_end joins the sweep; loads and batch_end during it are ignored.
    grad_valid = 1; grad_layer = 3; grad_row = 1; grad_stream = 24'h400000;
    batch_end = 1;
    tick();
    idle_in();
    begin
      int n = 0;
      while (n < 100 && done !== 1'b1) begin
        if (n >= 3) begin
          wr_en = 1; wr_layer = 3; wr_row = 1; wr_data = 24'h555555;
          batch_end = 1;
        end
        tick();
        n++;
      end
      check("same_cycle_done_lat", 64'(n), 64'(SWEEP));
    end
    idle_in();
    tick();
    check("same_cycle_no_resweep", 64'(busy), 64'd0);
    check_rd(3, 1, 24'hF00000, "same_cycle_w31");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      grad_valid  = ($urandom_range(1) == 1);
      grad_layer  = 2'($urandom_range(3));
      grad_row    = 2'($urandom_range(3));
      grad_stream = 24'($urandom);
      wr_en       = ($urandom_range(4) == 0);
      wr_layer    = 2'($urandom_range(3));
      wr_row      = 2'($urandom_range(3));
      wr_data     = 24'($urandom);
      batch_end   = ($urandom_range(24) == 0);
      reset       = ($urandom_range(150) == 0);
      rd_layer    = 2'($urandom_range(3));
      rd_row      = 2'($urandom_range(3));
      tick();
      compare_model("rand");
    end
    reset = 0;
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
